camera_pixel_packer: RTL and testbench

//   Write-side producer for the camera clock-crossing FIFO. Samples the 8-bit camera byte bus
//   (vsync/href, two bytes per RGB565 pixel), packs 16 pixels into one 256-bit word and pulses
//   wr_clk_en into the FIFO write port in the slow_clk (pixel clock) domain.

---
 rtl/camera_pixel_packer.sv | 190 +++++++++++++++++++
 tb/tb_camera_pixel_packer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_pixel_packer.sv
// camera_pixel_packer
//   Write-side producer for the camera clock-crossing FIFO. Samples the 8-bit
//   camera byte bus (two bytes per RGB565 pixel, MSB first), packs N/16 pixels
//   into one N-bit word and strobes it into the FIFO write port. Tracks
//   frame/line framing, drops words while the FIFO is full and keeps sticky
//   error flags.
//
//   Ports (all in the slow_clk domain):
//     slow_clk    camera pixel clock
//     rst_n_slow  synchronous active-low reset
//     capture_en  arms capture, only looked at while idle
//     cam_vsync   frame sync, high between frames
//     cam_href    line valid, one byte sampled per cycle while high
//     cam_data    camera byte
//     full        FIFO full
//     clear_err   pulse, clears overflow/line_err/frame_err
//     data_out    packed word to FIFO data_in (held between writes)
//     wr_clk_en   one-cycle FIFO write strobe
//     busy        high while waiting for frame start or capturing
//     frame_done  one-cycle pulse after the last line of a frame
//     overflow    sticky, a completed word was dropped on full
//     line_err    sticky, a line ended with the wrong byte count
//     frame_err   sticky, vsync rose before the frame was complete
module camera_pixel_packer #(
  parameter int unsigned N     = 256,
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic         slow_clk,
  input  logic         rst_n_slow,
  input  logic         capture_en,
  input  logic         cam_vsync,
  input  logic         cam_href,
  input  logic [7:0]   cam_data,
  input  logic         full,
  input  logic         clear_err,
  output logic [N-1:0] data_out,
  output logic         wr_clk_en,
  output logic         busy,
  output logic         frame_done,
  output logic         overflow,
  output logic         line_err,
  output logic         frame_err
);

  localparam int unsigned BPW = N / 8;
  localparam int unsigned BCW = $clog2(BPW);
  localparam int unsigned LBW = $clog2(2 * H_RES) + 1;
  localparam int unsigned LCW = $clog2(V_RES) + 1;

  localparam logic [BCW-1:0] LAST_BYTE  = BCW'(BPW - 1);
  localparam logic [LBW-1:0] LINE_BYTES = LBW'(2 * H_RES);
  localparam logic [LCW-1:0] LAST_LINE  = LCW'(V_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE
  } state_t;

  state_t         state_q;
  logic           vsync_q;
  logic           href_q;
  logic [BCW-1:0] byte_cnt_q;
  logic [LBW-1:0] line_bytes_q;
  logic [LCW-1:0] line_cnt_q;
  logic [N-1:0]   word_q;

  logic           vs_rise;
  logic           vs_fall;
  logic           hr_rise;
  logic           hr_fall;
  logic [BCW-1:0] byte_idx;
  logic [BCW-1:0] lane;
  logic [LBW-1:0] line_bytes_eff;
  logic [LBW-1:0] line_bytes_d;
  logic [N-1:0]   word_d;
  logic           word_last;

  always_comb begin
    vs_rise = cam_vsync & ~vsync_q;
    vs_fall = ~cam_vsync & vsync_q;
    hr_rise = cam_href & ~href_q;
    hr_fall = ~cam_href & href_q;

    // The first byte of a line is counted as byte 0 in the same cycle the
    // rising edge is seen, so the counters are overridden rather than cleared
    // a cycle early.
    byte_idx       = hr_rise ? '0 : byte_cnt_q;
    line_bytes_eff = hr_rise ? '0 : line_bytes_q;
    line_bytes_d   = (line_bytes_eff == '1) ? line_bytes_eff : line_bytes_eff + 1'b1;

    // Even byte is the pixel MSB, so byte c lands in byte lane c^1.
    lane   = byte_idx ^ BCW'(1);
    word_d = word_q;
    word_d[{lane, 3'b000} +: 8] = cam_data;

    word_last = (byte_idx == LAST_BYTE);
  end

  always_ff @(posedge slow_clk) begin
    if (!rst_n_slow) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      byte_cnt_q   <= '0;
      line_bytes_q <= '0;
      line_cnt_q   <= '0;
      word_q       <= '0;
      data_out     <= '0;
      wr_clk_en    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      line_err     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      wr_clk_en  <= 1'b0;
      frame_done <= 1'b0;

      // Clears first; any set below overrides because the later NBA wins.
      overflow  <= overflow  & ~clear_err;
      line_err  <= line_err  & ~clear_err;
      frame_err <= frame_err & ~clear_err;

      unique case (state_q)
        ST_IDLE: begin
          if (capture_en && vs_rise) begin
            state_q <= ST_SYNC;
            busy    <= 1'b1;
          end
        end

        ST_SYNC: begin
          if (vs_fall) begin
            state_q      <= ST_ACTIVE;
            byte_cnt_q   <= '0;
            line_bytes_q <= '0;
            line_cnt_q   <= '0;
          end
        end

        ST_ACTIVE: begin
          if (vs_rise) begin
            state_q      <= ST_SYNC;
            frame_err    <= 1'b1;
            byte_cnt_q   <= '0;
            line_bytes_q <= '0;
            line_cnt_q   <= '0;
          end else if (hr_fall) begin
            // Resetting byte_cnt discards any partial word of a bad line.
            byte_cnt_q   <= '0;
            line_bytes_q <= '0;
            if (line_bytes_q != LINE_BYTES) begin
              line_err <= 1'b1;
            end
            if (line_cnt_q == LAST_LINE) begin
              state_q    <= ST_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              line_cnt_q <= '0;
            end else begin
              line_cnt_q <= line_cnt_q + 1'b1;
            end
          end else if (cam_href) begin
            word_q       <= word_d;
            byte_cnt_q   <= byte_idx + 1'b1;
            line_bytes_q <= line_bytes_d;
            if (word_last) begin
              if (full) begin
                overflow <= 1'b1;
              end else begin
                data_out  <= word_d;
                wr_clk_en <= 1'b1;
              end
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_pixel_packer.sv
// Self-checking bench for camera_pixel_packer with H_RES=32, V_RES=2.
// Expected FIFO words are pushed to a queue as bytes are driven and popped by
// a monitor whenever the DUT strobes wr_clk_en.
module tb_camera_pixel_packer;

  localparam int unsigned N     = 256;
  localparam int unsigned H_RES = 32;
  localparam int unsigned V_RES = 2;

  logic         slow_clk = 1'b0;
  logic         rst_n_slow;
  logic         capture_en;
  logic         cam_vsync;
  logic         cam_href;
  logic [7:0]   cam_data;
  logic         full;
  logic         clear_err;
  logic [N-1:0] data_out;
  logic         wr_clk_en;
  logic         busy;
  logic         frame_done;
  logic         overflow;
  logic         line_err;
  logic         frame_err;

  camera_pixel_packer #(
    .N     (N),
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) dut (
    .slow_clk   (slow_clk),
    .rst_n_slow (rst_n_slow),
    .capture_en (capture_en),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .full       (full),
    .clear_err  (clear_err),
    .data_out   (data_out),
    .wr_clk_en  (wr_clk_en),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  always #5 slow_clk = ~slow_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobes = 0;
  int fd_cnt = 0;
  int fd_cyc = -1;
  int last_fall_cyc = -1;
  logic [N-1:0] first_word;
  logic [N-1:0] exp_q[$];

  always @(posedge slow_clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge slow_clk) begin
    if (rst_n_slow === 1'b1 && wr_clk_en === 1'b1) begin
      logic [N-1:0] e;
      if (strobes == 0) first_word = data_out;
      strobes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got data_out=%h, required no strobe", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL word: got %h required %h", data_out, e);
        end
      end
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  // Expected word for bytes base..base+31, pixel 0 at the LSBs.
  function automatic logic [N-1:0] mk_word(input int base);
    logic [N-1:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      w[16*k +: 16] = {8'(base + 2*k), 8'(base + 2*k + 1)};
    end
    return w;
  endfunction

  task automatic start_frame();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  // Drives one line; full (and optionally clear_err) is raised on byte full_at.
  task automatic drive_line(input int nbytes, input int base, input int full_at,
                            input bit clr_at_full, input bit expect_words);
    for (int i = 0; i < nbytes; i++) begin
      cam_href  = 1'b1;
      cam_data  = 8'(base + i);
      full      = (i == full_at);
      clear_err = clr_at_full && (i == full_at);
      if (expect_words && (i % 32 == 31) && (i != full_at)) begin
        exp_q.push_back(mk_word(base + i - 31));
      end
      tick();
    end
    cam_href      = 1'b0;
    cam_data      = 8'h00;
    full          = 1'b0;
    clear_err     = 1'b0;
    last_fall_cyc = cyc;
    repeat (4) tick();
  endtask

  task automatic check_drained(input string name);
    repeat (4) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_strobes: got %0d pending, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_slow = 1'b0;
    capture_en = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
    full       = 1'b0;
    clear_err  = 1'b0;
    repeat (3) tick();
    total++;
    if ({wr_clk_en, busy, frame_done, overflow, line_err, frame_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 000000",
               {wr_clk_en, busy, frame_done, overflow, line_err, frame_err});
    end
    total++;
    if (data_out !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h required 0", data_out);
    end
    rst_n_slow = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int s0, f0;
    s0 = strobes;
    f0 = fd_cnt;
    capture_en = 1'b1;
    start_frame();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL nominal_busy: got %b required 1", busy);
    end
    drive_line(64, 0, -1, 1'b0, 1'b1);
    drive_line(64, 0, -1, 1'b0, 1'b1);
    check_drained("nominal");
    total++;
    if (strobes - s0 != 4) begin
      bad++;
      $display("FAIL nominal_strobes: got %0d required 4", strobes - s0);
    end
    total++;
    if (first_word[15:0] !== 16'h0001 || first_word[255:240] !== 16'h1E1F) begin
      bad++;
      $display("FAIL nominal_first_word: got %h/%h required 1e1f/0001",
               first_word[255:240], first_word[15:0]);
    end
    total++;
    if (fd_cnt - f0 != 1 || fd_cyc != last_fall_cyc + 1) begin
      bad++;
      $display("FAIL nominal_frame_done: got %0d pulses at cycle %0d required 1 at %0d",
               fd_cnt - f0, fd_cyc, last_fall_cyc + 1);
    end
    total++;
    if ({busy, overflow, line_err, frame_err} !== 4'b0) begin
      bad++;
      $display("FAIL nominal_idle_flags: got %b required 0000",
               {busy, overflow, line_err, frame_err});
    end
  endtask

  task automatic test_fifo_full();
    int s0;
    s0 = strobes;
    start_frame();
    // clear_err in the same cycle as the drop: the set must win.
    drive_line(64, 8'h40, 63, 1'b1, 1'b1);
    total++;
    if (data_out !== mk_word(8'h40)) begin
      bad++;
      $display("FAIL full_data_held: got %h required %h", data_out, mk_word(8'h40));
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL full_overflow: got %b required 1", overflow);
    end
    drive_line(64, 8'h80, -1, 1'b0, 1'b1);
    check_drained("full");
    total++;
    if (strobes - s0 != 3) begin
      bad++;
      $display("FAIL full_strobes: got %0d required 3", strobes - s0);
    end
    do_clear();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_clear: got %b required 0", overflow);
    end
  endtask

  task automatic test_short_line();
    int s0;
    s0 = strobes;
    start_frame();
    drive_line(40, 8'h20, -1, 1'b0, 1'b1);
    total++;
    if (line_err !== 1'b1) begin
      bad++;
      $display("FAIL short_line_err: got %b required 1", line_err);
    end
    total++;
    if (strobes - s0 != 1) begin
      bad++;
      $display("FAIL short_line1_strobes: got %0d required 1", strobes - s0);
    end
    drive_line(64, 8'hA0, -1, 1'b0, 1'b1);
    check_drained("short");
    total++;
    if (strobes - s0 != 3) begin
      bad++;
      $display("FAIL short_strobes: got %0d required 3", strobes - s0);
    end
    do_clear();
  endtask

  task automatic test_early_vsync();
    int s0;
    s0 = strobes;
    start_frame();
    drive_line(64, 8'h10, -1, 1'b0, 1'b1);
    cam_vsync = 1'b1;
    tick();
    total++;
    if (frame_err !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL early_vsync: got frame_err=%b busy=%b required 1 1", frame_err, busy);
    end
    repeat (2) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    drive_line(64, 8'h50, -1, 1'b0, 1'b1);
    drive_line(64, 8'h90, -1, 1'b0, 1'b1);
    check_drained("early");
    total++;
    if (strobes - s0 != 6) begin
      bad++;
      $display("FAIL early_strobes: got %0d required 6", strobes - s0);
    end
    do_clear();
    total++;
    if ({overflow, line_err, frame_err} !== 3'b0) begin
      bad++;
      $display("FAIL early_clear: got %b required 000", {overflow, line_err, frame_err});
    end
  endtask

  task automatic test_arming();
    int s0;
    s0 = strobes;
    capture_en = 1'b0;
    start_frame();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL arming_busy: got %b required 0", busy);
    end
    drive_line(64, 8'h33, -1, 1'b0, 1'b0);
    drive_line(64, 8'h77, -1, 1'b0, 1'b0);
    check_drained("arming");
    total++;
    if (strobes - s0 != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL arming_strobes: got %0d busy=%b required 0 0", strobes - s0, busy);
    end
    capture_en = 1'b1;
  endtask

  task automatic test_reset_midline();
    int s0;
    s0 = strobes;
    start_frame();
    for (int i = 0; i < 20; i++) begin
      cam_href = 1'b1;
      cam_data = 8'(8'hC0 + i);
      tick();
    end
    rst_n_slow = 1'b0;
    cam_data   = 8'hD4;
    tick();
    total++;
    if (data_out !== '0 || {wr_clk_en, busy, frame_done, overflow, line_err, frame_err} !== 6'b0) begin
      bad++;
      $display("FAIL midline_reset: got data_out=%h flags=%b required 0", data_out,
               {wr_clk_en, busy, frame_done, overflow, line_err, frame_err});
    end
    tick();
    rst_n_slow = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cam_data = 8'(8'hE0 + i);
      tick();
    end
    cam_href = 1'b0;
    repeat (3) tick();
    start_frame();
    drive_line(64, 8'h05, -1, 1'b0, 1'b1);
    drive_line(64, 8'h45, -1, 1'b0, 1'b1);
    check_drained("midline");
    total++;
    if (strobes - s0 != 4) begin
      bad++;
      $display("FAIL midline_strobes: got %0d required 4", strobes - s0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fifo_full();
    test_short_line();
    test_early_vsync();
    test_arming();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
